// File: rtl/demux_rr_sched.sv
// ---------------------------------------------------------------------------
// demux_rr_sched
//   Round-robin scheduler that time-shares one 2-to-4 enable-gated demux
//   among four level-sensitive requesters. The current owner keeps the demux
//   for up to HOLD cycles while others wait. If nobody else is waiting, the
//   dwell counter reloads and the owner keeps the demux.
//
//   Optional feature macro: DEMUX_SCHED_GAP_EN
//     defined   - every change of owner passes through one GAP cycle with
//                 en/gnt low, so two demux outputs are never active on
//                 consecutive cycles.
//     undefined - ownership can move in a single edge (en stays high).
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] level request, req[i] asks for demux output z[i]
//   gnt    out  [3:0] one-hot grant, 0000 when nobody owns the demux
//   a      out  demux select LSB (sel[0])
//   b      out  demux select MSB (sel[1])
//   en     out  demux enable, high exactly when gnt is non-zero
//   busy   out  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module demux_rr_sched #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       a,
  output logic       b,
  output logic       en,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef DEMUX_SCHED_GAP_EN
    S_GAP   = 2'd2,
`endif
    S_GRANT = 2'd1
  } state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  function automatic logic [3:0] onehot(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

  // Round-robin pick: first asserted request scanning from p upward, mod 4.
  // Returns {found, index}.
  function automatic logic [2:0] arb(input logic [3:0] rq, input logic [1:0] p);
    logic       found;
    logic [1:0] idx;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = p + i[1:0];
      if (!found && rq[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  state_t     r_state;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [3:0] r_gnt;
  logic       r_en;
  logic       r_busy;

  logic [1:0] w_arb_ptr;
  logic       w_win_vld;
  logic [1:0] w_win;
  logic       w_other;
  logic       w_release;

  // While granting, the only arbitration that can happen is the same-edge
  // handover after a release, which already sees the advanced pointer.
  assign w_arb_ptr          = (r_state == S_GRANT) ? (r_sel + 2'd1) : r_ptr;
  assign {w_win_vld, w_win} = arb(req, w_arb_ptr);
  assign w_other            = |(req & ~onehot(r_sel));
  // An owner dropping its request wins over everything, including the
  // cnt==0 case, so a simultaneous drop and expiry is a single release.
  assign w_release          = !req[r_sel] || ((r_cnt == 4'd0) && w_other);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_sel   <= w_win;
            r_gnt   <= onehot(w_win);
            r_en    <= 1'b1;
            r_cnt   <= HOLD_M1;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (w_release) begin
            // Released channel becomes lowest priority next time.
            r_ptr <= r_sel + 2'd1;
`ifdef DEMUX_SCHED_GAP_EN
            r_gnt   <= 4'b0000;
            r_en    <= 1'b0;
            r_state <= S_GAP;
`else
            if (w_win_vld) begin
              r_sel   <= w_win;
              r_gnt   <= onehot(w_win);
              r_en    <= 1'b1;
              r_cnt   <= HOLD_M1;
              r_state <= S_GRANT;
            end else begin
              r_gnt   <= 4'b0000;
              r_en    <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
`endif
          end else if (r_cnt == 4'd0) begin
            // Sole requester: restart the slice and keep the grant.
            r_cnt <= HOLD_M1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

`ifdef DEMUX_SCHED_GAP_EN
        S_GAP: begin
          // Requests are sampled at the end of the dead cycle.
          if (w_win_vld) begin
            r_sel   <= w_win;
            r_gnt   <= onehot(w_win);
            r_en    <= 1'b1;
            r_cnt   <= HOLD_M1;
            r_state <= S_GRANT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`endif

        default: begin
          r_gnt   <= 4'b0000;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Select lines follow the registered owner, so they only move with a new
  // grant and hold their value while en is low.
  assign a    = r_sel[0];
  assign b    = r_sel[1];
  assign gnt  = r_gnt;
  assign en   = r_en;
  assign busy = r_busy;

endmodule

// File: tb/tb_demux_rr_sched.sv
module tb_demux_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       a;
  logic       b;
  logic       en;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb_q[$];

  demux_rr_sched #(.HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .a     (a),
    .b     (b),
    .en    (en),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector: {busy, en, b, a, gnt}
  function automatic logic [7:0] outs();
    return {busy, en, b, a, gnt};
  endfunction

  function automatic logic [7:0] pack(input logic [3:0] g, input logic e,
                                      input logic [1:0] s, input logic bz);
    return {bz, e, s[1], s[0], g};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got {busy,en,b,a,gnt}=%b expected %b at %0t", tag, obs, expv, $time);
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after the
  // following rising edge.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] g,
                      input logic e, input logic [1:0] s, input logic bz);
    exp_t x;
    @(negedge clk);
    req = r;
    x.tag = tag;
    x.v   = pack(g, e, s, bz);
    sb_q.push_back(x);
  endtask

  // Dead cycle between owners; absent when ownership moves in one edge.
  task automatic gap(input string tag, input logic [3:0] r, input logic [1:0] s);
`ifdef DEMUX_SCHED_GAP_EN
    step(tag, r, 4'b0000, 1'b0, s, 1'b1);
`endif
  endtask

  // Asynchronous reset pulse away from any clock edge, checked immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(tag, outs(), 8'h00);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard consumer
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk(x.tag, outs(), x.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", outs(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;

    // Full contention: 0001,0010,0100,1000,0001, four cycles each
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++)
        step("contend", 4'b1111, 4'b0001 << (i % 4), 1'b1, 2'(i % 4), 1'b1);
      if (i < 4) gap("contend_gap", 4'b1111, 2'(i % 4));
    end
    do_reset("rst_midgrant");

    // Single requester holds through counter reloads
    for (int i = 0; i < 20; i++)
      step("single", 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1);
`ifdef DEMUX_SCHED_GAP_EN
    step("single_rel", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1);
    step("single_idle", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
`else
    step("single_rel", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
`endif
    step("single_hold", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
    do_reset("rst_b");

    // Early release of channel 1 (ptr -> 2), then wrap from channel 3 to 0
    step("early", 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1);
    step("early", 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
    gap("early_gap", 4'b1001, 2'd1);
    for (int j = 0; j < 4; j++)
      step("early_next", 4'b1001, 4'b1000, 1'b1, 2'd3, 1'b1);
    gap("wrap_gap", 4'b1001, 2'd3);
    step("wrap", 4'b1001, 4'b0001, 1'b1, 2'd0, 1'b1);
`ifdef DEMUX_SCHED_GAP_EN
    step("wrap_rel", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
`endif
    step("wrap_idle", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    do_reset("rst_c");

    // Two requesters: 0001 x4 then 0010 x4 then back to 0001
    for (int j = 0; j < 4; j++)
      step("pair0", 4'b0011, 4'b0001, 1'b1, 2'd0, 1'b1);
    gap("pair_gap0", 4'b0011, 2'd0);
    for (int j = 0; j < 4; j++)
      step("pair1", 4'b0011, 4'b0010, 1'b1, 2'd1, 1'b1);
    gap("pair_gap1", 4'b0011, 2'd1);
    step("pair0b", 4'b0011, 4'b0001, 1'b1, 2'd0, 1'b1);
    do_reset("rst_d");

    // Owner drops its request exactly as the counter expires: one release
    for (int j = 0; j < 4; j++)
      step("dropexp", 4'b0011, 4'b0001, 1'b1, 2'd0, 1'b1);
    gap("dropexp_gap", 4'b0010, 2'd0);
    for (int j = 0; j < 7; j++)
      step("dropexp_own", 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler that shares the 2-to-4 enable-gated demultiplexer between four requesting destination channels. It arbitrates among level-sensitive requests and drives the demux select lines `a` (LSB) and `b` (MSB) and enable `en`, so the selected output is `z[{b,a}]`. Each grant is time-sliced by a dwell counter. An optional dead cycle between grants keeps the demux outputs from switching directly between channels.

## Interface

Parameters:
- `HOLD`, default 4: maximum grant dwell in cycles while other requests are pending. Legal range is 1..15.

Ports:
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  level request per channel; `req[i]` asks for demux output `z[i]`.
- `gnt`  out  4  one-hot grant. All zero when no channel owns the demux.
- `a`  out  1  demux select LSB. Equal to `sel[0]`.
- `b`  out  1  demux select MSB. Equal to `sel[1]`.
- `en`  out  1  demux enable. 1 exactly when `gnt` is non-zero.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation

All outputs are registered.

Internal state:
- 2-bit `sel` (current channel).
- 2-bit `ptr` (highest-priority channel for the next arbitration).
- 4-bit `cnt` (dwell counter).
- FSM with states IDLE, GRANT and GAP. GAP exists only with the macro defined.

Reset (asynchronous, takes effect immediately):
- State is IDLE.
- `sel`, `ptr` and `cnt` are 0.
- `a`, `b` and `en` are 0; `gnt` is 0000; `busy` is 0.

Arbitration:
- The winner is the first asserted `req[k]`, with `k` scanned in the order `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- On a win: `sel` gets the winner, `gnt` gets its one-hot code, `en` is 1, `cnt` is `HOLD-1`, and the state moves to GRANT.

IDLE:
- Arbitrates every cycle.
- Stays in IDLE while `req` is 0000.

GRANT, evaluated in priority order:
1. If `req[sel]` is 0, release.
2. If `cnt` is 0 and some other `req` bit is 1, release (preempt).
3. If `cnt` is 0 and no other request is pending, reload `cnt` to `HOLD-1` and keep the grant.
4. Otherwise, decrement `cnt`.

Release:
- `ptr` gets `sel+1` mod 4, so 3 wraps to 0.
- With the macro defined: `en` is 0, `gnt` is 0000, and the state moves to GAP.
- Without the macro: arbitrate in the same edge, using the updated `ptr`. If there is a winner, go to GRANT with it. Otherwise set `en` to 0, `gnt` to 0000, and go to IDLE.

GAP:
- Lasts exactly one cycle with `en` at 0.
- Arbitrates at its end, going to GRANT on a winner or to IDLE otherwise.

Select hold:
- `a` and `b` hold their last value whenever `en` is 0.
- They change only together with a new grant.

Boundary conditions:
- A request dropping in the same cycle that `cnt` reaches 0 causes one release.
- The released channel is lowest priority in the next arbitration. It is re-granted only if no other channel requests.
- Requests that change during GAP are sampled at the end of GAP.
- With `HOLD=1`, every pending competitor preempts the owner after 1 cycle.

## Timing

- Request-to-grant latency from IDLE: 1 edge. A `req` sampled at edge N produces `gnt`, `a`, `b` and `en` valid after edge N.
- Dwell under contention: `HOLD` cycles with `en` at 1.
- Switch-over between channels:
  - Macro defined: 1 cycle with `en` at 0.
  - Macro undefined: 0 cycles.
- Release on request drop: `req[sel]` falling before edge N clears the grant at edge N. A back-to-back switch also happens at edge N.
- Reset asserted mid-grant clears all outputs combinationally through the asynchronous reset, with no clock edge required.

## Configuration

`DEMUX_SCHED_GAP_EN`:
- Defined: the GAP state exists. Every change of owner passes through one cycle with `en` and `gnt` at 0, so no two demux outputs are ever active on consecutive cycles.
- Undefined: there is no GAP state. Ownership can move in one edge, with `en` staying 1 while `a` and `b` change.

## Test plan

`HOLD=4` throughout.

1. **Reset:** hold `rst_n` at 0 with `req` at 1111. Require `gnt`=0000, `a`=`b`=`en`=0 and `busy`=0. Assert `rst_n` mid-grant and require the same values immediately.
2. **Single requester:** `req` goes to 0100 from IDLE. After one edge require `gnt`=0100, `b`=1, `a`=0, `en`=1. The grant holds for 20 cycles because the counter reloads.
3. **Full contention, macro defined:** `req`=1111 from reset. Require the grant sequence 0001, 0010, 0100, 1000, 0001, each lasting 4 cycles. Each pair of grants is separated by 1 cycle with `en` at 0.
4. **Early release:** `req` is 0010 and then drops after 2 granted cycles while `req[3]` is 1. Require release at that edge, `ptr`=2, and the next grant to be 1000.
5. **Macro undefined:** `req`=0011. Require `gnt` 0001 for 4 cycles, then 0010 on the next edge with `en` continuously 1 and `a` going from 0 to 1.
6. **Wrap-around:** the owner is channel 3 with `req`=1001 and `cnt` expiring. Require the next grant to be 0001, meaning `ptr` wrapped to 0.
